// File: rtl/regfile_if.sv
// Register-file access bus: one write port and one combinational read port.
// The CPU datapath drives the master side; the register file sits on the slave side.
interface regfile_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 1
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ADDR_WIDTH-1:0] rsel;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output we,
    output waddr,
    output wdata,
    output rsel,
    input  rdata
  );

  modport slave (
    input  we,
    input  waddr,
    input  wdata,
    input  rsel,
    output rdata
  );
endinterface : regfile_if

// File: rtl/regfile.sv
// Small register file for the eight-bit datapath: NUM_REGS x DATA_WIDTH flops,
// one synchronous write port, one combinational read port, asynchronous clear.
module regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 2,
  parameter int ADDR_WIDTH = 1
) (
  input  logic     clk,
  input  logic     reset,     // active-low despite the name
  regfile_if.slave bus
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   w_wen;
  logic                  w_we_valid;
  logic [DATA_WIDTH-1:0] w_rdata;

  // An X/Z write enable must never open a write; in synthesis this is just we.
  assign w_we_valid = (bus.we === 1'b1);

  // One-hot write decode. Out-of-range addresses match no register, and an
  // X address never compares true, so neither can disturb stored data.
  always_comb begin
    // NOTE: every comb output gets a default first, otherwise the tool infers a latch.
    w_wen = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_we_valid && (bus.waddr == ADDR_WIDTH'(i))) begin
        w_wen[i] = 1'b1;
      end
    end
  end

  // NOTE: this array is tiny and must read 0 out of reset, so it is built from
  // resettable flops rather than a RAM macro, which could not be cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wen[i]) begin
          r_regs[i] <= bus.wdata;
        end
      end
    end
  end

  // Read mux with no write bypass; indices past NUM_REGS read as 0.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rsel == ADDR_WIDTH'(i)) begin
        w_rdata = r_regs[i];
      end
    end
  end

  assign bus.rdata = w_rdata;

endmodule : regfile

// File: tb/tb_regfile.sv
// Directed, table-driven bench for regfile in its default 2 x 8-bit configuration.
module tb_regfile;

  localparam int DW = 8;
  localparam int NR = 2;
  localparam int AW = 1;

  logic clk;
  logic reset;

  regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: rdata=%h expected=%h", name, act, req);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] rsel;
    logic [DW-1:0] rdata_exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  // One vector: drive on the falling edge, clock once, sample 1 unit after the rising edge.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    bus.we    = v.we;
    bus.waddr = v.waddr;
    bus.wdata = v.wdata;
    bus.rsel  = v.rsel;
    @(posedge clk);
    #1;
    check(name, bus.rdata, v.rdata_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{we:1'b1, waddr:1'b0, wdata:8'hAA, rsel:1'b0, rdata_exp:8'hAA}; // write reg0
    vecs[1]  = '{we:1'b0, waddr:1'b0, wdata:8'hAA, rsel:1'b1, rdata_exp:8'h00}; // reg1 untouched
    vecs[2]  = '{we:1'b1, waddr:1'b1, wdata:8'hFF, rsel:1'b1, rdata_exp:8'hFF}; // write reg1
    vecs[3]  = '{we:1'b0, waddr:1'b1, wdata:8'hFF, rsel:1'b0, rdata_exp:8'hAA}; // reg0 kept
    vecs[4]  = '{we:1'b0, waddr:1'b0, wdata:8'h55, rsel:1'b0, rdata_exp:8'hAA}; // hold
    vecs[5]  = '{we:1'b0, waddr:1'b1, wdata:8'h55, rsel:1'b1, rdata_exp:8'hFF}; // hold
    vecs[6]  = '{we:1'b0, waddr:1'b0, wdata:8'h55, rsel:1'b1, rdata_exp:8'hFF}; // hold
    vecs[7]  = '{we:1'b0, waddr:1'b1, wdata:8'h55, rsel:1'b0, rdata_exp:8'hAA}; // hold
    vecs[8]  = '{we:1'b1, waddr:1'b1, wdata:8'h5A, rsel:1'b0, rdata_exp:8'hAA}; // only reg1 moves
    vecs[9]  = '{we:1'b0, waddr:1'b1, wdata:8'h00, rsel:1'b1, rdata_exp:8'h5A};
    vecs[10] = '{we:1'b1, waddr:1'b1, wdata:8'hFF, rsel:1'b1, rdata_exp:8'hFF};
    vecs[11] = '{we:1'b0, waddr:1'b0, wdata:8'h00, rsel:1'b0, rdata_exp:8'hAA};

    // Reset held low; a write attempted during reset must not land.
    reset     = 1'b0;
    bus.we    = 1'b0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.rsel  = '0;
    #2;
    check("reset_rsel0", bus.rdata, 8'h00);
    bus.rsel = 1'b1;
    #1;
    check("reset_rsel1", bus.rdata, 8'h00);
    bus.we    = 1'b1;
    bus.waddr = 1'b0;
    bus.wdata = 8'hAA;
    bus.rsel  = 1'b0;
    @(posedge clk);
    #1;
    check("reset_overrides_write", bus.rdata, 8'h00);
    bus.we = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("post_release_rsel0", bus.rdata, 8'h00);
    bus.rsel = 1'b1;
    #1;
    check("post_release_rsel1", bus.rdata, 8'h00);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Read port follows rsel with no clock.
    bus.rsel = 1'b1;
    #1;
    check("comb_read_rsel1", bus.rdata, 8'hFF);
    bus.rsel = 1'b0;
    #1;
    check("comb_read_rsel0", bus.rdata, 8'hAA);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_rsel0", bus.rdata, 8'h00);
    bus.rsel = 1'b1;
    #1;
    check("async_reset_rsel1", bus.rdata, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("after_async_rsel1", bus.rdata, 8'h00);
    bus.rsel = 1'b0;
    #1;
    check("after_async_rsel0", bus.rdata, 8'h00);

    // Read-during-write to the same index: no bypass.
    @(negedge clk);
    bus.we    = 1'b1;
    bus.waddr = 1'b0;
    bus.wdata = 8'hAA;
    bus.rsel  = 1'b0;
    @(posedge clk);
    #1;
    check("rdw_setup", bus.rdata, 8'hAA);
    @(negedge clk);
    bus.wdata = 8'h3C;
    #1;
    check("rdw_before_edge", bus.rdata, 8'hAA);
    @(posedge clk);
    #1;
    check("rdw_after_edge", bus.rdata, 8'h3C);
    bus.we = 1'b0;
    bus.rsel = 1'b1;
    #1;
    check("rdw_other_reg", bus.rdata, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile

// File: doc/regfile.md
Name: regfile

Overview:
- Small synchronous register file for the eight-bit computer datapath.
- Provides one write port and one combinational read port over NUM_REGS registers of DATA_WIDTH bits.
- Holds CPU working registers; default configuration is two 8-bit registers, register 0 and register 1.

Parameters:
- DATA_WIDTH, 8, width of each register and of wdata/rdata.
- NUM_REGS, 2, number of registers; legal range 2..16.
- ADDR_WIDTH, 1, width of waddr/rsel; must equal ceil(log2(NUM_REGS)).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-low reset: 0 = reset asserted. The port keeps the codebase name "reset" despite the low polarity.
- we  input  1  write enable, sampled on rising clk.
- waddr  input  ADDR_WIDTH  index of the register to write.
- wdata  input  DATA_WIDTH  data to write.
- rsel  input  ADDR_WIDTH  index of the register to read.
- rdata  output  DATA_WIDTH  contents of register rsel.

Behaviour:
- Storage: NUM_REGS flops of DATA_WIDTH bits each, indexed 0..NUM_REGS-1.
- Reset:
  - reset=0 clears every register to 0 immediately, without waiting for clk.
  - rdata therefore reads 0 during reset, whatever rsel is.
  - Reset overrides any write in the same cycle.
  - Release (reset 0->1) is synchronised externally; the first write can occur on the first rising edge after release.
- Write:
  - On rising clk with reset=1 and we=1, register[waddr] <= wdata. Latency is one edge.
  - With we=0, all registers hold.
  - Only the addressed register changes; every other register holds.
- Read:
  - Purely combinational: rdata = register[rsel]. No clock latency; rdata follows rsel changes in the same delta.
- Read-during-write to the same index: no bypass.
  - Before the edge, rdata shows the old value.
  - After the edge, rdata shows the new value.
- Out-of-range index, when NUM_REGS is not a power of 2:
  - A write with waddr >= NUM_REGS is ignored; no register changes.
  - A read with rsel >= NUM_REGS returns 0.
- X handling: an X/Z value on we or waddr must not corrupt registers in synthesis. In simulation, treat we as 0 unless it is exactly 1.
- No internal state beyond the register array. No reset-value parameters: reset value is always 0.

Test Plan:
1. Reset: hold reset=0 for 10 time units, then release. Both rsel=0 and rsel=1 -> rdata=8'h00.
2. Write reg0: wdata=8'hAA, waddr=0, we=1 for one rising edge, then we=0 and rsel=0 -> rdata=8'hAA. Reg1 is still 8'h00.
3. Write reg1: wdata=8'hFF, waddr=1, we=1 for one edge, then rsel=1 -> rdata=8'hFF. Rsel=0 still gives 8'hAA.
4. Hold: we=0 with wdata=8'h55, waddr=0 toggling over several edges. Reg0 stays 8'hAA and reg1 stays 8'hFF.
5. Async reset mid-operation: reset=0 asserted between clock edges with reg0=8'hAA. Rdata drops to 8'h00 before the next edge; both registers read 8'h00 after release.
6. Read-during-write: rsel=0, reg0=8'hAA, write 8'h3C to reg0. Rdata=8'hAA before the edge and 8'h3C immediately after it.
